// File: rtl/alu_sequencer.sv
// Command sequencer owning the shared 32-bit ALU.
// Single-cycle ops go through EXEC; MUL is a shift-add loop on the ALU adder.
module alu_sequencer #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_overflow,
  output logic        res_zero,
  output logic        res_negative,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_negative
);

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SLT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  op_q;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  iter;
  logic [31:0] acc_next;
  logic        mul_last;
  logic        accept;
  logic        cap_en;
  logic        cap_ovf;
  logic [31:0] cap_data;

  // The ALU zero flag is redundant: zero is taken from res_data.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign accept    = cmd_valid && cmd_ready;

  // In MUL, alu_A mirrors acc and alu_B mirrors mcand.
  assign acc_next = mplier[0] ? alu_out : acc;
  assign mul_last = (iter == 5'd31) ||
                    (EARLY_EXIT && (mplier[31:1] == 31'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid)
          state_d = (cmd_op == OP_MUL) ? MUL : EXEC;
      end
      EXEC: state_d = DONE;
      MUL:  if (mul_last) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_en   = 1'b0;
    cap_ovf  = 1'b0;
    cap_data = acc_next;
    unique case (state_q)
      EXEC: begin
        cap_en   = 1'b1;
        cap_data = alu_out;
        unique case (op_q)
          OP_SLT: cap_data = {31'd0, alu_negative ^ alu_overflow};
          OP_ADD, OP_SUB: cap_ovf = alu_overflow;
          default: ;
        endcase
      end
      MUL: cap_en = mul_last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_ADD;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      iter        <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_control <= OP_ADD;
    end else if (accept) begin
      op_q <= cmd_op;
      if (cmd_op == OP_MUL) begin
        acc         <= '0;
        mcand       <= cmd_a;
        mplier      <= cmd_b;
        iter        <= '0;
        alu_A       <= '0;
        alu_B       <= cmd_a;
        alu_control <= OP_ADD;
      end else begin
        alu_A       <= cmd_a;
        alu_B       <= cmd_b;
        alu_control <= (cmd_op == OP_SLT) ? OP_SUB : cmd_op;
      end
    end else if (state_q == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + 5'd1;
      alu_A  <= acc_next;
      alu_B  <= mcand << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_zero     <= 1'b0;
      res_negative <= 1'b0;
    end else if (cap_en) begin
      res_data     <= cap_data;
      res_overflow <= cap_ovf;
      res_zero     <= (cap_data == 32'd0);
      res_negative <= cap_data[31];
    end
  end

endmodule
